// File: rtl/rf_wb_if.sv
// Write-back bus bundle: ALU and load producers, reservation port, register
// file write port and scoreboard status.
interface rf_wb_if #(
    parameter int DW   = 8,
    parameter int AW   = 3,
    parameter int NREG = 8
);
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_addr;
    logic [DW-1:0]   alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic            rsv_valid;
    logic            rsv_ready;
    logic [AW-1:0]   rsv_addr;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic [NREG-1:0] busy;
    logic            err;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output rsv_valid, rsv_addr,
        input  alu_ready, mem_ready, rsv_ready,
        input  rf_wen, rf_waddr, rf_wdata, busy, err
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  rsv_valid, rsv_addr,
        output alu_ready, mem_ready, rsv_ready,
        output rf_wen, rf_waddr, rf_wdata, busy, err
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for two one-entry producer buffers, plus a
// per-register outstanding-write scoreboard for issue-stage hazard stalls.
//
// state     | meaning
// GRANT_ALU | ALU won the most recent commit
// GRANT_MEM | MEM won the most recent commit (reset value, ALU wins first tie)
module rf_wb_arbiter #(
    parameter int DW   = 8,
    parameter int AW   = 3,
    parameter int NREG = 8
) (
    input logic   clk,
    input logic   reset,
    rf_wb_if.slave wb
);
    typedef enum logic {GRANT_ALU, GRANT_MEM} grant_t;

    grant_t          last_grant, last_grant_nxt;
    logic            alu_buf_valid, mem_buf_valid;
    logic [AW-1:0]   alu_buf_addr, mem_buf_addr;
    logic [DW-1:0]   alu_buf_data, mem_buf_data;
    logic            grant_alu, grant_mem;
    logic            commit;
    logic [AW-1:0]   commit_addr;
    logic [DW-1:0]   commit_data;
    logic            rsv_accept;
    logic [1:0]      cnt [NREG];
    logic [NREG-1:0] inc_vec, com_vec;
    logic            err_q;

    always_ff @(posedge clk) begin
        if (reset) last_grant <= GRANT_MEM;
        else       last_grant <= last_grant_nxt;
    end

    always_comb begin
        grant_alu      = alu_buf_valid && (!mem_buf_valid || last_grant == GRANT_MEM);
        grant_mem      = mem_buf_valid && !grant_alu;
        commit         = alu_buf_valid || mem_buf_valid;
        commit_addr    = grant_alu ? alu_buf_addr : mem_buf_addr;
        commit_data    = grant_alu ? alu_buf_data : mem_buf_data;
        last_grant_nxt = last_grant;
        if (grant_alu)      last_grant_nxt = GRANT_ALU;
        else if (grant_mem) last_grant_nxt = GRANT_MEM;
    end

    assign wb.alu_ready = !alu_buf_valid;
    assign wb.mem_ready = !mem_buf_valid;
    assign wb.rf_wen    = commit;
    assign wb.rf_waddr  = commit_addr;
    assign wb.rf_wdata  = commit_data;
    assign wb.rsv_ready = (cnt[wb.rsv_addr] != 2'd3);
    assign wb.err       = err_q;
    assign rsv_accept   = wb.rsv_valid && wb.rsv_ready;

    always_comb begin
        wb.busy = '0;
        inc_vec = '0;
        com_vec = '0;
        for (int i = 0; i < NREG; i++) begin
            wb.busy[i] = (cnt[i] != 2'd0);
            inc_vec[i] = rsv_accept && (wb.rsv_addr == AW'(i));
            com_vec[i] = commit && (commit_addr == AW'(i));
        end
    end

    // Ready is registered-empty, so a buffer never loads and drains on one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_buf_valid <= 1'b0;
            alu_buf_addr  <= '0;
            alu_buf_data  <= '0;
            mem_buf_valid <= 1'b0;
            mem_buf_addr  <= '0;
            mem_buf_data  <= '0;
        end else begin
            if (wb.alu_valid && !alu_buf_valid) begin
                alu_buf_valid <= 1'b1;
                alu_buf_addr  <= wb.alu_addr;
                alu_buf_data  <= wb.alu_data;
            end else if (grant_alu) begin
                alu_buf_valid <= 1'b0;
            end
            if (wb.mem_valid && !mem_buf_valid) begin
                mem_buf_valid <= 1'b1;
                mem_buf_addr  <= wb.mem_addr;
                mem_buf_data  <= wb.mem_data;
            end else if (grant_mem) begin
                mem_buf_valid <= 1'b0;
            end
        end
    end

    // A reservation landing with a commit to the same register nets to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= 2'd0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (inc_vec[i] && !com_vec[i])
                    cnt[i] <= cnt[i] + 2'd1;
                else if (com_vec[i] && !inc_vec[i] && cnt[i] != 2'd0)
                    cnt[i] <= cnt[i] - 2'd1;
            end
            if (commit && !inc_vec[commit_addr] && cnt[commit_addr] == 2'd0)
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized checks of rf_wb_arbiter against a queue/count
// reference model evaluated once per cycle.
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    rf_wb_if #(.DW(8), .AW(3), .NREG(8)) wb ();

    rf_wb_arbiter #(.DW(8), .AW(3), .NREG(8)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    always #5 clk = ~clk;

    // Reference model: pending entry per producer, who won last, counts.
    bit       a_v, m_v, last_alu, err_m;
    bit [2:0] a_a, m_a;
    bit [7:0] a_d, m_d;
    int       cnt_m [8];
    bit [7:0] got [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        a_v = 0; m_v = 0; last_alu = 0; err_m = 0;
        a_a = 0; m_a = 0; a_d = 0; m_d = 0;
        for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    endtask

    task automatic step(input bit rst, input bit av, input bit [2:0] aa, input bit [7:0] ad,
                        input bit mv, input bit [2:0] ma, input bit [7:0] md,
                        input bit rv, input bit [2:0] ra);
        bit       e_wen, pick_alu, e_rdy, a_v0, m_v0;
        bit [2:0] e_addr;
        bit [7:0] e_data, busy_e;
        int       delta [8];
        int       n;
        @(negedge clk);
        reset = rst;
        wb.alu_valid = av; wb.alu_addr = aa; wb.alu_data = ad;
        wb.mem_valid = mv; wb.mem_addr = ma; wb.mem_data = md;
        wb.rsv_valid = rv; wb.rsv_addr = ra;
        #1;
        e_wen    = a_v || m_v;
        pick_alu = a_v && (!m_v || !last_alu);
        e_addr   = pick_alu ? a_a : m_a;
        e_data   = pick_alu ? a_d : m_d;
        e_rdy    = (cnt_m[ra] != 3);
        for (int i = 0; i < 8; i++) busy_e[i] = (cnt_m[i] != 0);
        check("alu_ready", 32'(wb.alu_ready), 32'(!a_v));
        check("mem_ready", 32'(wb.mem_ready), 32'(!m_v));
        check("rf_wen",    32'(wb.rf_wen),    32'(e_wen));
        check("rsv_ready", 32'(wb.rsv_ready), 32'(e_rdy));
        check("busy",      32'(wb.busy),      32'(busy_e));
        check("err",       32'(wb.err),       32'(err_m));
        if (e_wen) begin
            check("rf_waddr", 32'(wb.rf_waddr), 32'(e_addr));
            check("rf_wdata", 32'(wb.rf_wdata), 32'(e_data));
        end
        if (wb.rf_wen === 1'b1) got.push_back(wb.rf_wdata);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 8; i++) delta[i] = 0;
            if (rv && e_rdy) delta[ra] += 1;
            if (e_wen) delta[e_addr] -= 1;
            for (int i = 0; i < 8; i++) begin
                n = cnt_m[i] + delta[i];
                if (n < 0) begin err_m = 1; n = 0; end
                cnt_m[i] = n;
            end
            a_v0 = a_v; m_v0 = m_v;
            if (e_wen) begin
                if (pick_alu) a_v = 0; else m_v = 0;
                last_alu = pick_alu;
            end
            if (av && !a_v0) begin a_v = 1; a_a = aa; a_d = ad; end
            if (mv && !m_v0) begin m_v = 1; m_a = ma; m_d = md; end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1;
        wb.alu_valid = 0; wb.alu_addr = 0; wb.alu_data = 0;
        wb.mem_valid = 0; wb.mem_addr = 0; wb.mem_data = 0;
        wb.rsv_valid = 0; wb.rsv_addr = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset values
        idle();
        check("rst_alu_ready", 32'(wb.alu_ready), 32'd1);
        check("rst_mem_ready", 32'(wb.mem_ready), 32'd1);
        check("rst_rf_wen",    32'(wb.rf_wen),    32'd0);
        check("rst_rf_waddr",  32'(wb.rf_waddr),  32'd0);
        check("rst_rf_wdata",  32'(wb.rf_wdata),  32'd0);
        check("rst_busy",      32'(wb.busy),      32'd0);
        check("rst_rsv_ready", 32'(wb.rsv_ready), 32'd1);
        check("rst_err",       32'(wb.err),       32'd0);

        // Single ALU write
        step(0, 1, 3'd3, 8'h5A, 0, 0, 0, 0, 0);
        idle();
        check("single_alu_ready", 32'(wb.alu_ready), 32'd0);
        check("single_wen",   32'(wb.rf_wen),   32'd1);
        check("single_waddr", 32'(wb.rf_waddr), 32'd3);
        check("single_wdata", 32'(wb.rf_wdata), 32'h5A);
        idle();
        check("single_wen_off",   32'(wb.rf_wen),    32'd0);
        check("single_alu_ready1", 32'(wb.alu_ready), 32'd1);

        // Tie fairness from reset
        do_reset();
        step(0, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 0);
        idle();
        check("tie_first_addr", 32'(wb.rf_waddr), 32'd1);
        check("tie_first_data", 32'(wb.rf_wdata), 32'h11);
        idle();
        check("tie_second_addr", 32'(wb.rf_waddr), 32'd2);
        check("tie_second_data", 32'(wb.rf_wdata), 32'h22);
        for (int k = 0; k < 6; k++)
            step(0, 1, 3'(k), 8'(8'h40 + k), 1, 3'(k + 1), 8'(8'h80 + k), 0, 0);

        // Back-pressure: 6 cycles of ALU valid with changing data
        do_reset();
        got.delete();
        for (int k = 0; k < 6; k++) step(0, 1, 3'd4, 8'(8'hB0 + k), 0, 0, 0, 0, 0);
        idle(); idle();
        check("bp_commits", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("bp_data0", 32'(got[0]), 32'hB0);
            check("bp_data1", 32'(got[1]), 32'hB2);
            check("bp_data2", 32'(got[2]), 32'hB4);
        end

        // Scoreboard saturation and simultaneous reserve/commit
        do_reset();
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 3'd5);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3'd5);
        check("sat_rsv_ready", 32'(wb.rsv_ready), 32'd0);
        check("sat_busy5",     32'(wb.busy[5]),   32'd1);
        step(0, 1, 3'd5, 8'hA1, 0, 0, 0, 0, 0);
        idle();
        step(0, 1, 3'd5, 8'hA2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3'd5);
        step(0, 0, 0, 0, 0, 0, 0, 0, 3'd5);
        check("simul_rsv_ready", 32'(wb.rsv_ready), 32'd1);
        step(0, 1, 3'd5, 8'hA3, 0, 0, 0, 0, 0);
        idle();
        step(0, 0, 0, 0, 1, 3'd5, 8'hA4, 0, 0);
        idle();
        idle();
        check("drain_busy5", 32'(wb.busy[5]), 32'd0);
        check("drain_err",   32'(wb.err),     32'd0);

        // Underflow
        step(0, 1, 3'd6, 8'h66, 0, 0, 0, 0, 0);
        idle();
        idle();
        check("uf_err",   32'(wb.err),     32'd1);
        check("uf_busy6", 32'(wb.busy[6]), 32'd0);
        repeat (3) idle();
        check("uf_err_sticky", 32'(wb.err), 32'd1);
        do_reset();
        idle();
        check("uf_err_cleared", 32'(wb.err), 32'd0);

        // Mid-operation reset with both buffers full
        step(0, 0, 0, 0, 0, 0, 0, 1, 3'd1);
        step(0, 1, 3'd1, 8'hC1, 1, 3'd2, 8'hC2, 0, 0);
        do_reset();
        got.delete();
        idle();
        check("mr_wen",       32'(wb.rf_wen),    32'd0);
        check("mr_alu_ready", 32'(wb.alu_ready), 32'd1);
        check("mr_mem_ready", 32'(wb.mem_ready), 32'd1);
        check("mr_busy",      32'(wb.busy),      32'd0);
        check("mr_rf_waddr",  32'(wb.rf_waddr),  32'd0);
        check("mr_rf_wdata",  32'(wb.rf_wdata),  32'd0);
        repeat (3) idle();
        check("mr_no_commits", 32'(got.size()), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
